// File: rtl/cordic_iter_hs.sv
// Iterative CORDIC engine (rotate / vector) with valid-ready handshakes on input and output.
// Optional macro GAIN_COMP_EN adds a COMP state that removes the CORDIC gain from x and y.
module cordic_iter_hs #(
    parameter int unsigned XY_W  = 17,
    parameter int unsigned TH_W  = 17,
    parameter int unsigned ITERS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode_i,
    input  logic signed [XY_W-1:0] x_i,
    input  logic signed [XY_W-1:0] y_i,
    input  logic signed [TH_W-1:0] theta_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [XY_W-1:0] x_o,
    output logic signed [XY_W-1:0] y_o,
    output logic signed [TH_W-1:0] theta_o
);
    localparam int unsigned IW = XY_W + 2;
    localparam int unsigned ZW = TH_W + 1;
    localparam int unsigned PW = 2 * XY_W + 2;
    // ROM holds 30 fractional bits; the angle format has TH_W-2 (TH_W <= 32).
    localparam int unsigned SH = 32 - TH_W;
    localparam logic [32:0] ATAN_RND = (SH > 0) ? (33'd1 << (SH - 1)) : 33'd0;
    localparam logic [4:0] LAST = 5'(ITERS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StComp, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic signed [IW-1:0]   r_x;
    logic signed [IW-1:0]   r_y;
    logic signed [ZW-1:0]   r_z;
    logic                   r_mode;
    logic [4:0]             r_cnt;
    logic signed [XY_W-1:0] r_x_o;
    logic signed [XY_W-1:0] r_y_o;
    logic signed [TH_W-1:0] r_theta_o;

    logic signed [IW-1:0]   w_xs;
    logic signed [IW-1:0]   w_ys;
    logic signed [IW-1:0]   w_x_nxt;
    logic signed [IW-1:0]   w_y_nxt;
    logic signed [ZW-1:0]   w_atan;
    logic signed [ZW-1:0]   w_z_nxt;
    logic                   w_dpos;
    logic                   w_load_out;
    logic signed [XY_W-1:0] w_x_fin;
    logic signed [XY_W-1:0] w_y_fin;
    logic signed [TH_W-1:0] w_theta_fin;

    function automatic logic [ZW-1:0] atan_rom(input logic [4:0] idx);
        logic [31:0] v;
        logic [32:0] r;
        case (idx)
            5'd0:    v = 32'd843314857;
            5'd1:    v = 32'd497837829;
            5'd2:    v = 32'd263043837;
            5'd3:    v = 32'd133525159;
            5'd4:    v = 32'd67021687;
            5'd5:    v = 32'd33543516;
            5'd6:    v = 32'd16775851;
            5'd7:    v = 32'd8388437;
            5'd8:    v = 32'd4194283;
            5'd9:    v = 32'd2097149;
            5'd31:   v = 32'd0;
            // From i = 10 on, atan(2^-i) rounds to 2^-i at 30 fractional bits.
            default: v = 32'd1 << (5'd30 - idx);
        endcase
        r = {1'b0, v} + ATAN_RND;
        return r[SH +: ZW];
    endfunction

    function automatic logic signed [PW-1:0] ext_xy(input logic signed [IW-1:0] v);
        return {{(PW - IW){v[IW-1]}}, v};
    endfunction

    function automatic logic signed [XY_W-1:0] sat_xy(input logic signed [PW-1:0] v);
        if ((&v[PW-1:XY_W-1]) || !(|v[PW-1:XY_W-1])) begin
            return v[XY_W-1:0];
        end
        return v[PW-1] ? {1'b1, {(XY_W - 1){1'b0}}} : {1'b0, {(XY_W - 1){1'b1}}};
    endfunction

    function automatic logic signed [TH_W-1:0] sat_z(input logic signed [ZW-1:0] v);
        if (v[ZW-1] == v[ZW-2]) begin
            return v[TH_W-1:0];
        end
        return v[ZW-1] ? {1'b1, {(TH_W - 1){1'b0}}} : {1'b0, {(TH_W - 1){1'b1}}};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (in_valid) w_state_nxt = StRun;
            StRun: begin
                if (r_cnt == LAST) begin
`ifdef GAIN_COMP_EN
                    w_state_nxt = StComp;
`else
                    w_state_nxt = StDone;
`endif
                end
            end
            StComp: w_state_nxt = StDone;
            StDone: if (out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
    end

    always_comb begin
        w_xs   = r_x >>> r_cnt;
        w_ys   = r_y >>> r_cnt;
        w_atan = atan_rom(r_cnt);
        w_dpos = r_mode ? r_y[IW-1] : ~r_z[ZW-1];
        if (w_dpos) begin
            w_x_nxt = r_x - w_ys;
            w_y_nxt = r_y + w_xs;
            w_z_nxt = r_z - w_atan;
        end else begin
            w_x_nxt = r_x + w_ys;
            w_y_nxt = r_y - w_xs;
            w_z_nxt = r_z + w_atan;
        end
    end

`ifdef GAIN_COMP_EN
    // round(2^30 / K), rescaled to the XY fixed-point format and rounded.
    localparam logic [63:0] INV_K_Q30 = 64'd652032874;
    localparam logic [63:0] KINV_U = ((64'd1 << (XY_W - 2)) * INV_K_Q30 + (64'd1 << 29)) >> 30;
    localparam logic signed [PW-1:0] KINV = PW'(KINV_U);
    localparam logic signed [PW-1:0] PROD_RND = PW'(1) << (XY_W - 3);

    logic signed [PW-1:0] w_px;
    logic signed [PW-1:0] w_py;

    always_comb begin
        w_px        = (ext_xy(r_x) * KINV + PROD_RND) >>> (XY_W - 2);
        w_py        = (ext_xy(r_y) * KINV + PROD_RND) >>> (XY_W - 2);
        w_load_out  = (r_state == StComp);
        w_x_fin     = sat_xy(w_px);
        w_y_fin     = sat_xy(w_py);
        w_theta_fin = sat_z(r_z);
    end
`else
    always_comb begin
        w_load_out  = (r_state == StRun) && (r_cnt == LAST);
        w_x_fin     = sat_xy(ext_xy(w_x_nxt));
        w_y_fin     = sat_xy(ext_xy(w_y_nxt));
        w_theta_fin = sat_z(w_z_nxt);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_mode    <= 1'b0;
            r_cnt     <= '0;
            r_x_o     <= '0;
            r_y_o     <= '0;
            r_theta_o <= '0;
        end else begin
            if (r_state == StIdle && in_valid) begin
                r_x    <= {{2{x_i[XY_W-1]}}, x_i};
                r_y    <= {{2{y_i[XY_W-1]}}, y_i};
                r_z    <= mode_i ? '0 : {theta_i[TH_W-1], theta_i};
                r_mode <= mode_i;
                r_cnt  <= '0;
            end else if (r_state == StRun) begin
                r_x   <= w_x_nxt;
                r_y   <= w_y_nxt;
                r_z   <= w_z_nxt;
                r_cnt <= r_cnt + 5'd1;
            end
            if (w_load_out) begin
                r_x_o     <= w_x_fin;
                r_y_o     <= w_y_fin;
                r_theta_o <= w_theta_fin;
            end
        end
    end

    assign x_o     = r_x_o;
    assign y_o     = r_y_o;
    assign theta_o = r_theta_o;

endmodule
